// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: register addresses and edge-capture modes shared by the button PIO
package nios_pio_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_button_pio_if.sv
// nios_button_pio_if: Avalon-MM slave bus between the Nios data master and the button PIO
interface nios_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport slave (input address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: one button channel -- 2-FF synchroniser, debounce counter, stable level and its delayed copy
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic stable_d
);
    logic meta, sync;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {meta, sync, stable_d} <= '0;
        else {meta, sync, stable_d} <= {din, meta, stable};
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) stable <= 1'b0;
                else stable <= sync;
        end else begin : g_count
            logic [CNT_W-1:0] cnt;
            logic done;
            assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
            // any return to the stable level restarts the count, so short glitches never land
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync == stable) cnt <= '0;
                else if (done) begin
                    cnt    <= '0;
                    stable <= sync;
                end else cnt <= cnt + 1'b1;
        end
    endgenerate
endmodule

// File: rtl/nios_button_pio.sv
// nios_button_pio: Avalon-MM input PIO for push-buttons with debounce, edge capture, IRQ mask and level IRQ
module nios_button_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    nios_button_pio_if.slave   bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);
    logic [WIDTH-1:0] stable, stable_d, rise, fall, hit, clr, irqmask, edgecap;
    logic [31:0] rd_mux;
    logic wr, unused_wdata;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_ch
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
            .clk(clk), .reset_n(reset_n), .din(in_port[i]),
            .stable(stable[i]), .stable_d(stable_d[i])
        );
    end
    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign hit  = EDGE_TYPE == EDGE_ANY ? rise | fall : EDGE_TYPE == EDGE_FALL ? fall : rise;
    assign wr   = bus.chipselect & ~bus.write_n;
    assign clr  = wr && bus.address == ADDR_EDGECAP ? bus.writedata[WIDTH-1:0] : '0;
    assign irq  = |(edgecap & irqmask);
    assign unused_wdata = ^bus.writedata;
    always_comb
        rd_mux = bus.address == ADDR_DATA    ? 32'(stable)  :
                 bus.address == ADDR_IRQMASK ? 32'(irqmask) :
                 bus.address == ADDR_EDGECAP ? 32'(edgecap) : '0;
    // new edges are OR'd in after the clear so a coincident W1C never loses one
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            irqmask      <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
            edgecap      <= (edgecap & ~clr) | hit;
            bus.readdata <= rd_mux;
        end
endmodule

// File: tb/tb_nios_button_pio.sv
// tb_nios_button_pio: directed checks of two PIO instances (rising and falling capture) sharing one bus drive
module tb_nios_button_pio;
    logic clk = 1'b0, reset_n = 1'b1;
    logic [1:0] address = '0, in0 = '0, in1 = '0;
    logic chipselect = 1'b0, write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic irq0, irq1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    nios_button_pio_if bus0();
    nios_button_pio_if bus1();
    assign bus0.address = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;
    assign bus0.writedata = writedata;
    assign bus1.address = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;
    assign bus1.writedata = writedata;

    nios_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0)
    );
    nios_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick(1);
        check(tag, bus0.readdata, exp);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        rd_chk("rst_data", 0, 0);
        rd_chk("rst_addr1", 1, 0);
        rd_chk("rst_mask", 2, 0);
        rd_chk("rst_cap", 3, 0);
        check("rst_irq", irq0, 0);
        wr(2, 32'hFFFF_FFFF);
        rd_chk("mask_upper_zero", 2, 3);
        wr(2, 1);
        rd_chk("mask_01", 2, 1);
        wr(0, 32'hFFFF_FFFF);
        rd_chk("data_ro", 0, 0);
        wr(1, 32'hFFFF_FFFF);
        rd_chk("addr1_ro", 1, 0);
        // pin to DATA latency: 2 sync + 4 debounce + 1 readdata
        address = 0;
        in0 = 2'b01;
        tick(6);
        check("lat_before", bus0.readdata, 0);
        check("irq_before", irq0, 0);
        tick(1);
        check("lat_exact", bus0.readdata, 1);
        check("irq_set", irq0, 1);
        rd_chk("cap_set", 3, 1);
        wr(3, 0);
        check("w0_no_clear_irq", irq0, 1);
        rd_chk("w0_no_clear_cap", 3, 1);
        wr(3, 1);
        check("w1c_irq", irq0, 0);
        rd_chk("w1c_cap", 3, 0);
        // 3-clk glitch on ch1 must not pass a 4-clk debounce
        address = 0;
        in0 = 2'b11;
        tick(3);
        in0 = 2'b01;
        tick(10);
        rd_chk("glitch_data", 0, 1);
        rd_chk("glitch_cap", 3, 0);
        // W1C landing on the same clk as a fresh rising edge
        in0 = 2'b00;
        tick(10);
        rd_chk("release_data", 0, 0);
        rd_chk("fall_not_captured", 3, 0);
        in0 = 2'b01;
        tick(6);
        wr(3, 1);
        check("race_irq", irq0, 1);
        rd_chk("race_cap", 3, 1);
        wr(3, 1);
        rd_chk("race_cleared", 3, 0);
        // falling-edge instance
        address = 3;
        in1 = 2'b10;
        tick(10);
        check("fall_press", bus1.readdata, 0);
        in1 = 2'b00;
        tick(10);
        check("fall_release", bus1.readdata, 2);
        check("fall_irq_masked", irq1, 0);
        wr(2, 2);
        check("fall_irq_unmasked", irq1, 1);
        // reset in the middle of a debounce
        in0 = 2'b00;
        tick(10);
        in0 = 2'b01;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("rst_async_rd", bus1.readdata, 0);
        check("rst_async_irq", irq1, 0);
        in0 = 2'b00;
        tick(2);
        reset_n = 1'b1;
        address = 0;
        tick(10);
        check("rst_mid_data", bus0.readdata, 0);
        rd_chk("rst_mid_cap", 3, 0);
        rd_chk("rst_mid_mask", 2, 0);
        check("rst_mid_irq", irq0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
